// File: rtl/tff_count_ctrl.sv
// tff_count_ctrl: sequences a preset-to-ones TFF bank as a modulo-M counter with shadow-count feedback checking
module tff_count_ctrl #(
    parameter int WIDTH = 4,
    parameter int LAPW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] mod_val,
    input  logic [LAPW-1:0]  laps,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] t_out,
    output logic             tff_rst,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             wrap,
    output logic             done,
    output logic             err
);
    typedef enum logic [2:0] {IDLE, INIT, CLEAR, RUN, DONE, ERR} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_mod;
    logic [LAPW-1:0]  r_laps;
    logic [LAPW-1:0]  r_lap_cnt;
    logic [WIDTH-1:0] w_term;
    logic [WIDTH-1:0] w_inc;
    logic             w_fb_bad;
    logic             w_at_term;
    logic             w_last_lap;
    // M=0 underflows to all ones, giving the full 2^WIDTH modulus for free
    assign w_term     = r_mod - WIDTH'(1);
    assign w_fb_bad   = q_fb != count;
    assign w_at_term  = count == w_term;
    assign w_last_lap = (r_laps != '0) && (r_lap_cnt + LAPW'(1) == r_laps);
    assign w_inc[0]   = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_inc
        assign w_inc[i] = &q_fb[i-1:0];
    end
    assign tff_rst = rst && r_state == INIT;
    assign t_out   = !rst ? '0 :
                     (r_state == CLEAR && q_fb == '1) ? q_fb :
                     (r_state == RUN && !w_fb_bad && !stop) ? (w_at_term ? q_fb : w_inc) : '0;
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_mod     <= '0;
            r_laps    <= '0;
            r_lap_cnt <= '0;
            count     <= '0;
            busy      <= 1'b0;
            wrap      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            wrap <= 1'b0;
            done <= 1'b0;
            case (r_state)
                IDLE, ERR: if (start) begin
                    r_mod     <= mod_val;
                    r_laps    <= laps;
                    r_lap_cnt <= '0;
                    err       <= 1'b0;
                    busy      <= 1'b1;
                    r_state   <= INIT;
                end
                INIT: r_state <= CLEAR;
                CLEAR: if (q_fb != '1) begin
                    err     <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ERR;
                end else begin
                    count   <= '0;
                    r_state <= RUN;
                end
                RUN: if (w_fb_bad) begin
                    err     <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ERR;
                end else if (stop) begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end else if (w_at_term) begin
                    count     <= '0;
                    wrap      <= 1'b1;
                    r_lap_cnt <= (&r_lap_cnt) ? r_lap_cnt : r_lap_cnt + LAPW'(1);
                    if (w_last_lap) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= DONE;
                    end
                end else begin
                    count <= count + WIDTH'(1);
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tff_count_ctrl.sv
// tb_tff_count_ctrl: directed bench with a behavioural TFF bank and a queue of expected per-cycle outputs
module tb_tff_count_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] mod_val = '0;
    logic [7:0] laps = '0;
    logic [3:0] bq = 4'b0101;
    logic [3:0] fmask = '0;
    logic [3:0] q_fb, t_out, count;
    logic       tff_rst, busy, wrap, done, err;
    int         errors = 0;
    int         checks = 0;
    typedef struct packed {
        logic [3:0] cnt;
        logic       b, w, d, e;
        logic [3:0] t;
        logic       r;
    } exp_t;
    exp_t sb[$];

    tff_count_ctrl #(.WIDTH(4), .LAPW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mod_val(mod_val), .laps(laps),
        .q_fb(q_fb), .t_out(t_out), .tff_rst(tff_rst), .count(count), .busy(busy),
        .wrap(wrap), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge tff_rst) begin
        if (tff_rst) bq <= 4'hF;
        else bq <= bq ^ t_out;
    end
    assign q_fb = bq & ~fmask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [3:0] c, input logic b, input logic w, input logic d,
                        input logic e, input logic [3:0] t, input logic r, input string tag);
        exp_t x;
        sb.push_back(exp_t'{c, b, w, d, e, t, r});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk(tag, 32'({count, busy, wrap, done, err, t_out, tff_rst}), 32'(x));
    endtask

    task automatic startup(input logic [3:0] m, input logic [7:0] l, input logic [3:0] prev);
        start = 1'b1;
        mod_val = m;
        laps = l;
        tick(prev, 1, 0, 0, 0, 4'h0, 1, "init");
        start = 1'b0;
        tick(prev, 1, 0, 0, 0, 4'hF, 0, "clear");
    endtask

    initial begin
        #150000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        start = 1'b1;
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 4'h0, 0, "rst_hold");
        rst = 1'b1;
        start = 1'b0;
        tick(0, 0, 0, 0, 0, 4'h0, 0, "rst_idle");

        startup(5, 2, 0);
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < 5; c++)
                tick(4'(c), 1, l > 0 && c == 0, 0, 0, 4'(c ^ (c == 4 ? 0 : c + 1)), 0, "m5_run");
        tick(0, 0, 1, 1, 0, 4'h0, 0, "m5_done");
        tick(0, 0, 0, 0, 0, 4'h0, 0, "m5_idle");

        startup(0, 1, 0);
        for (int c = 0; c < 16; c++) tick(4'(c), 1, 0, 0, 0, 4'(c ^ (c + 1)), 0, "m0_run");
        tick(0, 0, 1, 1, 0, 4'h0, 0, "m0_done");
        tick(0, 0, 0, 0, 0, 4'h0, 0, "m0_idle");

        startup(1, 3, 0);
        for (int i = 0; i < 3; i++) tick(0, 1, i > 0, 0, 0, 4'h0, 0, "m1_run");
        tick(0, 0, 1, 1, 0, 4'h0, 0, "m1_done");
        tick(0, 0, 0, 0, 0, 4'h0, 0, "m1_idle");

        startup(0, 0, 0);
        for (int c = 0; c < 3; c++) tick(4'(c), 1, 0, 0, 0, 4'(c ^ (c + 1)), 0, "flt_run");
        fmask = 4'b0010;
        #1;
        chk("flt_t", 32'(t_out), 32'h0);
        tick(2, 0, 0, 0, 1, 4'h0, 0, "flt_err");
        stop = 1'b1;
        tick(2, 0, 0, 0, 1, 4'h0, 0, "flt_hold");
        tick(2, 0, 0, 0, 1, 4'h0, 0, "flt_hold");
        stop = 1'b0;
        fmask = '0;
        startup(5, 1, 2);
        for (int c = 0; c < 5; c++) tick(4'(c), 1, 0, 0, 0, 4'(c ^ (c == 4 ? 0 : c + 1)), 0, "rec_run");
        tick(0, 0, 1, 1, 0, 4'h0, 0, "rec_done");
        tick(0, 0, 0, 0, 0, 4'h0, 0, "rec_idle");

        startup(0, 0, 0);
        for (int c = 0; c < 4; c++) tick(4'(c), 1, 0, 0, 0, 4'(c ^ (c + 1)), 0, "stop_run");
        stop = 1'b1;
        #1;
        chk("stop_t", 32'(t_out), 32'h0);
        tick(3, 0, 0, 0, 0, 4'h0, 0, "stop_idle");
        stop = 1'b0;
        tick(3, 0, 0, 0, 0, 4'h0, 0, "stop_hold");
        startup(2, 1, 3);
        tick(0, 1, 0, 0, 0, 4'h1, 0, "m2_run");
        tick(1, 1, 0, 0, 0, 4'h1, 0, "m2_term");
        tick(0, 0, 1, 1, 0, 4'h0, 0, "m2_done");
        tick(0, 0, 0, 0, 0, 4'h0, 0, "m2_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tff_count_ctrl.md
Name: tff_count_ctrl

Overview:
Controller that sequences a bank of WIDTH toggle flip-flops (each with clk, async active-high rst that presets Q to 1, T, Q) as a synchronous modulo-M counter. It pulses the bank's reset, clears the preset-to-ones state via toggles, and drives per-bit T enables to count. It checks TFF feedback against an internal shadow count, reports wraps/completion, and sits between a host start/stop interface and the TFF bank.

Parameters:
WIDTH, 4, number of TFFs in the bank / counter width
LAPW, 8, width of laps counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-low reset
start  input  1  begin sequence; sampled in IDLE, DONE-free, ERR
stop  input  1  abort counting; sampled in RUN
mod_val  input  WIDTH  modulus M, latched at start
laps  input  LAPW  wraps before done, latched at start; 0 = run until stop
q_fb  input  WIDTH  Q outputs of TFF bank
t_out  output  WIDTH  T inputs of TFF bank (combinational)
tff_rst  output  1  active-high reset to TFF bank (combinational)
count  output  WIDTH  shadow count (registered)
busy  output  1  high in INIT/CLEAR/RUN (registered)
wrap  output  1  1-cycle pulse per modulus wrap (registered)
done  output  1  1-cycle pulse on lap completion (registered)
err  output  1  sticky feedback mismatch flag (registered)

Behaviour:
- Reset: rst=0 at clk edge -> state IDLE; count, busy, wrap, done, err, lap_cnt = 0. While rst=0, t_out=0 and tff_rst=0 regardless of state.
- States: IDLE, INIT, CLEAR, RUN, DONE, ERR.
- IDLE: t_out=0, tff_rst=0. start=1 -> latch mod_val, laps; lap_cnt<=0; err<=0; -> INIT.
- INIT (1 cycle): tff_rst=1, t_out=0 -> CLEAR. Bank Q becomes all ones.
- CLEAR (1 cycle): t_out=q_fb (toggle every set bit). If q_fb != all ones -> ERR, t_out=0. Else count<=0 -> RUN.
- RUN, priority high to low:
  - q_fb != count: t_out=0, err<=1 -> ERR.
  - stop=1: t_out=0 -> IDLE; count and bank hold value.
  - count == term: t_out=q_fb (return to 0); count<=0; wrap<=1 next cycle; lap_cnt<=lap_cnt+1. If laps!=0 and lap_cnt+1==laps -> DONE.
  - Otherwise: t_out[0]=1, t_out[i]=&q_fb[i-1:0]; count<=count+1.
- term = M-1. M=0 means 2^WIDTH (term = all ones). M=1 means term=0: wrap every cycle, t_out=0.
- lap_cnt saturates at all ones when laps=0; it never terminates.
- DONE (1 cycle): done=1, t_out=0 -> IDLE. busy drops the same cycle.
- ERR: t_out=0, err=1 held. start=1 -> relatch, clear err, -> INIT. stop is ignored.
- start outside IDLE/ERR is ignored. busy, done, wrap, err are registered from next-state.
- Reset during RUN: next edge -> IDLE; the bank is not reset by tff_rst. The next start re-initialises it via INIT.
- Latency: start edge -> first increment at the 3rd edge after start (INIT, CLEAR, RUN). count tracks bank Q each cycle.

Test Plan:
- Reset hold: rst=0 for 3 cycles with start=1 -> t_out=0, tff_rst=0, all registered outputs 0. Release -> IDLE.
- Basic count, WIDTH=4, M=5, laps=2: start -> tff_rst pulse for 1 cycle. CLEAR drives t_out=4'b1111. count runs 0,1,2,3,4,0,1,2,3,4,0. wrap pulses twice; done pulses once after the 2nd wrap; busy spans INIT..last RUN.
- Full modulus, M=0, laps=1: count 0..15 then 0 (16 increments). t_out=4'b1111 at 7->8 and wrap 15->0. One done.
- M=1, laps=3: count stays 0; wrap pulses 3 consecutive cycles, then done.
- Fault injection: force q_fb[1] stuck-at-0 once count reaches 2 -> err=1 on the next edge, t_out=0. ERR holds until start, and start clears err and replays INIT.
- stop mid-run at count=3, laps=0 -> IDLE next edge, count=3 held, t_out=0, no done. A new start re-inits from preset ones to 0.
